// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and helpers for pipelined_register_file and rf_scoreboard.
//   - default parameter values for the register file
//   - DEPTH / CNT_MAX for the default configuration
//   - bus_slice and its wrappers, which extract one port's field from the
//     flattened Rsrc (addresses) and RA (read data) buses
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;
  localparam int BYPASS_DEF   = 1;
  localparam int CNT_W_DEF    = 2;

  localparam int DEPTH   = 2 ** ADDR_W_DEF;
  localparam int CNT_MAX = 2 ** CNT_W_DEF - 1;

  // Widest flattened bus and widest single field the slicing helpers handle.
  localparam int BUS_MAX   = 1024;
  localparam int FIELD_MAX = 64;

  // Field idx of a bus made of equal-width fields, LSB-aligned and zero-padded.
  function automatic logic [FIELD_MAX-1:0] bus_slice(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        idx,
    input int unsigned        width
  );
    logic [BUS_MAX-1:0]   shifted;
    logic [FIELD_MAX-1:0] mask;
    shifted = bus >> (idx * width);
    mask    = (width >= FIELD_MAX) ? '1
                                   : ((FIELD_MAX'(1) << width) - FIELD_MAX'(1));
    return shifted[FIELD_MAX-1:0] & mask;
  endfunction

  // Read address of port `port` from the flattened Rsrc bus.
  function automatic logic [FIELD_MAX-1:0] rsrc_addr(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        port,
    input int unsigned        addr_w
  );
    return bus_slice(bus, port, addr_w);
  endfunction

  // Read data of port `port` from the flattened RA bus.
  function automatic logic [FIELD_MAX-1:0] ra_word(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        port,
    input int unsigned        data_w
  );
    return bus_slice(bus, port, data_w);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Per-register pending-write counters for read-after-write hazard detection.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   rd_addr         read address of each read port
//   bypass_hit      per port: a live same-cycle writeback matches rd_addr
//   wr_en, wr_addr  writeback strobe and destination
//   issue, issue_rd issuing instruction and its destination
//   issue_ready     pending counter of issue_rd is not saturated
//   hazard          per port: source still has an unsatisfied pending write
//   wb_err          sticky: writeback arrived with no pending write
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]              bypass_hit,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic                           issue,
  input  logic [ADDR_W-1:0]              issue_rd,
  output logic                           issue_ready,
  output logic [NUM_RD-1:0]              hazard,
  output logic                           wb_err
);

  localparam int               NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [CNT_W-1:0] pend      [NUM_REGS];
  logic [CNT_W-1:0] pend_next [NUM_REGS];
  logic             issue_take;
  logic             wb_orphan;

  // Readiness looks only at the current count; a same-cycle writeback does
  // not free a slot until the edge.
  assign issue_ready = (pend[issue_rd] != PEND_MAX);

  // The zero register never tracks writes, so r0 issues are accepted and ignored.
  assign issue_take = issue && issue_ready &&
                      !((ZERO_REG != 0) && (issue_rd == '0));

  assign wb_orphan  = wr_en && (pend[wr_addr] == '0) &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: every combinational output gets a default before any condition
  // touches it, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_next[r] = pend[r];
      if (issue_take && (issue_rd == ADDR_W'(r)))
        pend_next[r] = pend_next[r] + 1'b1;
      if (wr_en && (wr_addr == ADDR_W'(r)) && (pend[r] != '0))
        pend_next[r] = pend_next[r] - 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
      wb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_next[r];
      if (wb_orphan) wb_err <= 1'b1;
    end
  end

  // With exactly one outstanding write, a bypass hit satisfies it this
  // cycle; with more, a younger producer is still in flight.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_hz
    assign hazard[i] = (pend[rd_addr[i]] != '0) &&
                       !((BYPASS != 0) && (pend[rd_addr[i]] == CNT_W'(1)) &&
                         bypass_hit[i]);
  end

endmodule

// File: rtl/pipelined_register_file.sv
// -----------------------------------------------------------------------------
// pipelined_register_file
// Single-write, multi-read register file with optional hardwired zero
// register, same-cycle writeback bypass and a pending-write scoreboard.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   Rsrc / RA        flattened read addresses / read data, port i at field i
//   HAZARD           per port: source has an unsatisfied outstanding write
//   Rdst, RY         writeback destination and data
//   RF_WRITE         writeback strobe
//   ISSUE, ISSUE_RD  instruction issue and its destination register
//   ISSUE_READY      ISSUE_RD can accept another outstanding write
//   WB_ERR           sticky: writeback with no matching pending write
// -----------------------------------------------------------------------------
module pipelined_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   Rsrc,
  output logic [NUM_RD*DATA_W-1:0]   RA,
  output logic [NUM_RD-1:0]          HAZARD,
  input  logic [ADDR_W-1:0]          Rdst,
  input  logic [DATA_W-1:0]          RY,
  input  logic                       RF_WRITE,
  input  logic                       ISSUE,
  input  logic [ADDR_W-1:0]          ISSUE_RD,
  output logic                       ISSUE_READY,
  output logic                       WB_ERR
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]              regs [NUM_REGS];
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0]              bypass_hit;
  logic                           wr_live;

  // A write to r0 is discarded when r0 is hardwired to zero.
  assign wr_live = RF_WRITE && !((ZERO_REG != 0) && (Rdst == '0));

  // NOTE: the array is cleared on reset because the pipeline relies on
  // architecturally zeroed registers; that forces flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_live) begin
      regs[Rdst] <= RY;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] rd_word;

    assign rd_addr[i]    = ADDR_W'(rsrc_addr(BUS_MAX'(Rsrc), i, ADDR_W));
    assign bypass_hit[i] = (BYPASS != 0) && wr_live && (Rdst == rd_addr[i]);

    always_comb begin
      if ((ZERO_REG != 0) && (rd_addr[i] == '0)) rd_word = '0;
      else if (bypass_hit[i])                    rd_word = RY;
      else                                       rd_word = regs[rd_addr[i]];
    end

    assign RA[i*DATA_W +: DATA_W] = rd_word;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr     (rd_addr),
    .bypass_hit  (bypass_hit),
    .wr_en       (RF_WRITE),
    .wr_addr     (Rdst),
    .issue       (ISSUE),
    .issue_rd    (ISSUE_RD),
    .issue_ready (ISSUE_READY),
    .hazard      (HAZARD),
    .wb_err      (WB_ERR)
  );

endmodule

// File: tb/tb_pipelined_register_file.sv
// -----------------------------------------------------------------------------
// tb_pipelined_register_file
// Bench for pipelined_register_file with default parameters, plus a second
// instance with BYPASS = 0 sharing the same stimulus. Each test builds a list
// of per-cycle drives and pushes expected observations tagged with their
// cycle; the run loop drives each cycle and pops/compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_pipelined_register_file;
  import rf_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [9:0]  rsrc;
  logic [63:0] ra;
  logic [1:0]  hazard;
  logic [4:0]  rdst;
  logic [31:0] ry;
  logic        rf_write;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_err;

  logic [63:0] nb_ra;
  logic [1:0]  nb_hazard;
  logic        nb_issue_ready;
  logic        nb_wb_err;

  int checks   = 0;
  int failures = 0;

  pipelined_register_file dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rsrc        (rsrc),
    .RA          (ra),
    .HAZARD      (hazard),
    .Rdst        (rdst),
    .RY          (ry),
    .RF_WRITE    (rf_write),
    .ISSUE       (issue),
    .ISSUE_RD    (issue_rd),
    .ISSUE_READY (issue_ready),
    .WB_ERR      (wb_err)
  );

  pipelined_register_file #(.BYPASS(0)) dut_nb (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rsrc        (rsrc),
    .RA          (nb_ra),
    .HAZARD      (nb_hazard),
    .Rdst        (rdst),
    .RY          (ry),
    .RF_WRITE    (rf_write),
    .ISSUE       (issue),
    .ISSUE_RD    (issue_rd),
    .ISSUE_READY (nb_issue_ready),
    .WB_ERR      (nb_wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {O_RA0, O_RA1, O_HZ0, O_HZ1, O_RDY, O_ERR, O_NB_RA0} obs_e;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [4:0]  rdst;
    logic [31:0] ry;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
  } drv_t;

  typedef struct {
    int          cyc;
    obs_e        sel;
    logic [31:0] v;
    string       name;
  } exp_t;

  drv_t drv_q[$];
  exp_t sb[$];

  task automatic cyc(input logic rst_n, input logic wr, input logic [4:0] d,
                     input logic [31:0] y, input logic iss, input logic [4:0] ird,
                     input logic [4:0] rs0, input logic [4:0] rs1);
    drv_t s;
    s.rst_n = rst_n; s.wr = wr; s.rdst = d; s.ry = y;
    s.iss = iss; s.iss_rd = ird; s.rs0 = rs0; s.rs1 = rs1;
    drv_q.push_back(s);
  endtask

  // Expectation for the most recently scheduled cycle.
  task automatic expect_obs(input obs_e sel, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = drv_q.size() - 1; e.sel = sel; e.v = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic apply(input drv_t s);
    reset_n  = s.rst_n;
    rf_write = s.wr;
    rdst     = s.rdst;
    ry       = s.ry;
    issue    = s.iss;
    issue_rd = s.iss_rd;
    rsrc     = {s.rs1, s.rs0};
  endtask

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      O_RA0:    return 32'(ra_word(BUS_MAX'(ra), 0, 32));
      O_RA1:    return 32'(ra_word(BUS_MAX'(ra), 1, 32));
      O_HZ0:    return {31'd0, hazard[0]};
      O_HZ1:    return {31'd0, hazard[1]};
      O_RDY:    return {31'd0, issue_ready};
      O_ERR:    return {31'd0, wb_err};
      O_NB_RA0: return nb_ra[31:0];
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drv_q.delete(); sb.delete();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'(a), 5'(a), 5'(31 - a));
      expect_obs(O_RA0, 32'h0, "reset_ra0");
      expect_obs(O_RA1, 32'h0, "reset_ra1");
      expect_obs(O_HZ0, 32'd0, "reset_hazard0");
      expect_obs(O_HZ1, 32'd0, "reset_hazard1");
      expect_obs(O_RDY, 32'd1, "reset_issue_ready");
      expect_obs(O_ERR, 32'd0, "reset_wb_err");
      expect_obs(O_NB_RA0, 32'h0, "reset_nb_ra0");
    end
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_write_read();
    drv_q.delete(); sb.delete();
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    expect_obs(O_RA0, 32'hDEADBEEF, "r5_port0");
    expect_obs(O_RA1, 32'hDEADBEEF, "r5_port1");
    expect_obs(O_NB_RA0, 32'hDEADBEEF, "r5_nobypass");
    cyc(1'b1, 1'b1, 5'd6, 32'h0000_1234, 1'b0, 5'd0, 5'd6, 5'd5);
    expect_obs(O_RA0, 32'h0000_1234, "bypass_r6");
    expect_obs(O_NB_RA0, 32'h0, "nobypass_r6_old");
    expect_obs(O_RA1, 32'hDEADBEEF, "independent_port1");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd6);
    expect_obs(O_RA0, 32'h0000_1234, "r6_after_edge");
    expect_obs(O_RA1, 32'h0000_1234, "r6_after_edge_p1");
    expect_obs(O_NB_RA0, 32'h0000_1234, "nobypass_r6_new");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    drv_q.delete(); sb.delete();
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    expect_obs(O_RA0, 32'h0, "r0_no_bypass");
    expect_obs(O_RA1, 32'h0, "r0_no_bypass_p1");
    expect_obs(O_HZ0, 32'd0, "r0_hazard");
    expect_obs(O_RDY, 32'd1, "r0_ready");
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      expect_obs(O_HZ0, 32'd0, "r0_issue_hazard");
      expect_obs(O_RDY, 32'd1, "r0_issue_ready");
    end
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    expect_obs(O_RA0, 32'h0, "r0_after_write");
    expect_obs(O_NB_RA0, 32'h0, "r0_after_write_nb");
    expect_obs(O_HZ0, 32'd0, "r0_pending_zero");
    expect_obs(O_RDY, 32'd1, "r0_still_ready");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_issue_saturate();
    drv_q.delete(); sb.delete();
    // Three accepted issues to R7 (P: 0 -> 1 -> 2 -> 3), then a dropped fourth.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd8);
    expect_obs(O_RDY, 32'd1, "r7_ready_p0");
    expect_obs(O_HZ0, 32'd0, "r7_hazard_p0");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd8);
    expect_obs(O_RDY, 32'd1, "r7_ready_p1");
    expect_obs(O_HZ0, 32'd1, "r7_hazard_p1");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd8);
    expect_obs(O_RDY, 32'd1, "r7_ready_p2");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd8);
    expect_obs(O_RDY, 32'd0, "r7_full_not_ready");
    expect_obs(O_HZ0, 32'd1, "r7_hazard_p3");
    expect_obs(O_HZ1, 32'd0, "r8_no_hazard");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd8);
    expect_obs(O_RDY, 32'd0, "r7_fourth_dropped");
    expect_obs(O_HZ0, 32'd1, "r7_hazard_after_drop");
    // Writebacks: P=3 hit, P=2 hit, P=1 no hit, P=1 hit.
    cyc(1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd7, 5'd7, 5'd7);
    expect_obs(O_HZ0, 32'd1, "r7_p3_hit_hazard");
    expect_obs(O_HZ1, 32'd1, "r7_p3_hit_hazard1");
    expect_obs(O_RA0, 32'h0000_0077, "r7_bypass_77");
    expect_obs(O_NB_RA0, 32'h0, "r7_nobypass_old");
    cyc(1'b1, 1'b1, 5'd7, 32'h0000_0770, 1'b0, 5'd7, 5'd7, 5'd8);
    expect_obs(O_HZ0, 32'd1, "r7_p2_hit_hazard");
    expect_obs(O_RA0, 32'h0000_0770, "r7_bypass_770");
    expect_obs(O_RDY, 32'd1, "r7_ready_after_wb");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd8);
    expect_obs(O_HZ0, 32'd1, "r7_p1_nohit_hazard");
    expect_obs(O_RA0, 32'h0000_0770, "r7_stored_770");
    cyc(1'b1, 1'b1, 5'd7, 32'h0000_7777, 1'b0, 5'd7, 5'd7, 5'd8);
    expect_obs(O_HZ0, 32'd0, "r7_p1_hit_clears");
    expect_obs(O_HZ1, 32'd0, "r8_no_hazard_wb");
    expect_obs(O_RA0, 32'h0000_7777, "r7_bypass_7777");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd8);
    expect_obs(O_HZ0, 32'd0, "r7_drained");
    expect_obs(O_RDY, 32'd1, "r7_ready_drained");
    expect_obs(O_RA0, 32'h0000_7777, "r7_stored_7777");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_issue_and_wb();
    drv_q.delete(); sb.delete();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    expect_obs(O_HZ0, 32'd0, "r9_before_issue");
    // P[9] = 1: simultaneous issue and writeback leaves it at 1.
    cyc(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 5'd9, 5'd10);
    expect_obs(O_HZ0, 32'd0, "r9_p1_hit");
    expect_obs(O_HZ1, 32'd0, "r10_idle");
    expect_obs(O_RDY, 32'd1, "r9_ready");
    expect_obs(O_RA0, 32'h0000_0099, "r9_bypass");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd9);
    expect_obs(O_HZ0, 32'd1, "r9_still_pending");
    expect_obs(O_HZ1, 32'd1, "r9_still_pending1");
    expect_obs(O_RA0, 32'h0000_0099, "r9_stored");
    cyc(1'b1, 1'b1, 5'd9, 32'h0000_0098, 1'b0, 5'd9, 5'd9, 5'd9);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd9);
    expect_obs(O_HZ0, 32'd0, "r9_drained");
    expect_obs(O_RA0, 32'h0000_0098, "r9_stored_98");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_wb_err();
    drv_q.delete(); sb.delete();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd10);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd10);
    expect_obs(O_ERR, 32'd0, "err_clear_after_reset");
    expect_obs(O_RA0, 32'h0, "r10_zero");
    cyc(1'b1, 1'b1, 5'd10, 32'h0000_A0A0, 1'b0, 5'd0, 5'd10, 5'd0);
    expect_obs(O_ERR, 32'd0, "err_not_yet");
    expect_obs(O_RA0, 32'h0000_A0A0, "r10_bypass");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    expect_obs(O_ERR, 32'd1, "err_set");
    expect_obs(O_RA0, 32'h0000_A0A0, "r10_written");
    expect_obs(O_HZ0, 32'd0, "r10_no_hazard");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    expect_obs(O_ERR, 32'd1, "err_sticky");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    expect_obs(O_ERR, 32'd1, "err_until_edge");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    expect_obs(O_ERR, 32'd0, "err_cleared");
    expect_obs(O_RA0, 32'h0, "r10_cleared");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drv_q.delete(); sb.delete();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    expect_obs(O_HZ0, 32'd0, "r3_before_issue");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    expect_obs(O_HZ0, 32'd1, "r3_p1");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd3);
    expect_obs(O_HZ0, 32'd1, "r3_p2");
    expect_obs(O_RDY, 32'd1, "r3_p2_ready");
    // Reset together with a writeback and an issue to R3.
    cyc(1'b0, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 5'd3, 5'd3);
    expect_obs(O_HZ0, 32'd1, "r3_p2_hit_in_reset");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd3);
    expect_obs(O_RA0, 32'h0, "r3_not_written");
    expect_obs(O_RA1, 32'h0, "r3_not_written1");
    expect_obs(O_NB_RA0, 32'h0, "r3_not_written_nb");
    expect_obs(O_HZ0, 32'd0, "r3_pending_forgotten");
    expect_obs(O_RDY, 32'd1, "r3_ready_after_reset");
    expect_obs(O_ERR, 32'd0, "err_zero_after_reset");
    // Late writeback for a forgotten issue: data lands, WB_ERR sets.
    cyc(1'b1, 1'b1, 5'd3, 32'h0000_3333, 1'b0, 5'd3, 5'd3, 5'd3);
    expect_obs(O_HZ0, 32'd0, "r3_late_wb_hazard");
    expect_obs(O_RA0, 32'h0000_3333, "r3_late_bypass");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd3);
    expect_obs(O_RA0, 32'h0000_3333, "r3_late_written");
    expect_obs(O_ERR, 32'd1, "err_late_wb");
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drv_q.delete(); sb.delete();
    // Write R1..R8 on consecutive cycles; port 0 reads the register being
    // written (bypass), port 1 the one written the cycle before.
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] d_now, d_prev;
      d_now  = 32'h1000_0000 + 32'(i * 32'h111);
      d_prev = (i == 1) ? 32'h0 : 32'h1000_0000 + 32'((i - 1) * 32'h111);
      cyc(1'b1, 1'b1, 5'(i), d_now, 1'b0, 5'd0, 5'(i), 5'(i - 1));
      expect_obs(O_RA0, d_now, "b2b_bypass");
      expect_obs(O_RA1, d_prev, "b2b_prev");
    end
    foreach (drv_q[k]) begin
      @(posedge clk); #1; apply(drv_q[k]);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        exp_t e; logic [31:0] got;
        e = sb.pop_front(); got = observe(e.sel); checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", e.name, got, e.v, k);
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    rf_write = 1'b0;
    rdst     = '0;
    ry       = '0;
    issue    = 1'b0;
    issue_rd = '0;
    rsrc     = '0;

    test_reset();
    test_write_read();
    test_zero_reg();
    test_issue_saturate();
    test_issue_and_wb();
    test_back_to_back();
    test_wb_err();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_register_file.md
Name: pipelined_register_file

Overview:
Parametrised successor to the processor's single-write, dual-read register file. It adds configurable data width, depth and read-port count, a hardwired zero register, and same-cycle write-to-read bypass. It also carries a per-register pending-write scoreboard, so the pipelined datapath can detect read-after-write hazards against writes that are still in flight. It sits between decode (read ports, issue) and writeback (RY/Rdst).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (≥1)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports
CNT_W, 2, width of each per-register pending-write counter

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset_n  input  1  synchronous active-low reset; sampled only on rising clk edge
Rsrc  input  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
RA  output  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
HAZARD  output  NUM_RD  port i source has an outstanding write not satisfied this cycle
Rdst  input  ADDR_W  writeback destination
RY  input  DATA_W  writeback data
RF_WRITE  input  1  writeback strobe
ISSUE  input  1  an instruction writing ISSUE_RD issues this cycle
ISSUE_RD  input  ADDR_W  destination of the issuing instruction
ISSUE_READY  output  1  pending counter of ISSUE_RD is below its maximum
WB_ERR  output  1  sticky flag: a writeback arrived for a register with pending count 0

Behaviour:
- Reset: reset_n low at a rising clk edge clears all registers to 0, all pending counters to 0, and WB_ERR to 0. This has priority over write and issue in the same cycle. After reset, RA = 0, HAZARD = 0 and ISSUE_READY = 1.
- Write: at a rising edge with RF_WRITE = 1, R[Rdst] <= RY. When ZERO_REG = 1 and Rdst = 0, no write occurs.
- Read: combinational, zero latency. RA_i = R[Rsrc_i].
  - ZERO_REG = 1 and Rsrc_i = 0 gives RA_i = 0.
  - BYPASS = 1, RF_WRITE = 1 and Rdst = Rsrc_i (nonzero when ZERO_REG) gives RA_i = RY.
  - BYPASS = 0 gives the old value until the next cycle.
  - All read ports are independent; any two ports may read the same address.
- Pending counters: each register has P[r], CNT_W bits wide.
  - Increment when ISSUE = 1, ISSUE_READY = 1 and ISSUE_RD = r.
  - Decrement when RF_WRITE = 1, Rdst = r and P[r] > 0.
  - Issue and writeback to the same r in one cycle: net change 0.
  - Issue while ISSUE_READY = 0 is dropped: counter unchanged, no error raised. The issuer must stall.
  - ISSUE_READY = (P[ISSUE_RD] != 2**CNT_W-1). It is combinational on ISSUE_RD and current P, and does not credit a same-cycle writeback.
  - A writeback with P[Rdst] = 0 still writes the data, leaves P at 0, and sets WB_ERR on the next edge. WB_ERR clears only on reset.
  - ZERO_REG = 1: P[0] is constant 0; issue and writeback to r0 never touch it.
- HAZARD_i = (P[Rsrc_i] != 0), except that it is 0 when BYPASS = 1 and P[Rsrc_i] = 1 and a same-cycle bypass hit on port i. When P ≥ 2 a hazard remains even with a bypass hit, because a younger producer is still outstanding. HAZARD uses current P, not P after the edge.
- Mid-operation reset: in-flight issues are forgotten. Writebacks after reset for pre-reset issues write data and set WB_ERR.

Decomposition:
- Package rf_pkg holds:
  - default parameter constants;
  - localparam DEPTH = 2**ADDR_W;
  - CNT_MAX = 2**CNT_W-1;
  - helper functions to slice the flattened Rsrc and RA buses.
- One sub-module, rf_scoreboard, owns the pending counters, ISSUE_READY, HAZARD qualification and WB_ERR. The top level holds the storage array, write logic, and per-port read/bypass muxes built by a generate loop.

Test Plan:
- Reset then read all addresses on both ports → RA = 0 everywhere, HAZARD = 0, ISSUE_READY = 1, WB_ERR = 0.
- Write R5 = 0xDEADBEEF, next cycle Rsrc0 = Rsrc1 = 5 → both RA = 0xDEADBEEF. Same-cycle write R6 = 0x1234 with Rsrc0 = 6 → RA0 = 0x1234 (BYPASS = 1), old value when BYPASS = 0.
- Write R0 = 0xFFFFFFFF and issue to R0 → RA for address 0 = 0, P[0] stays 0, HAZARD = 0.
- Issue R7 three times (CNT_W = 2) → ISSUE_READY = 0 for ISSUE_RD = 7, a fourth issue is dropped, and HAZARD is 1 on port 0 with Rsrc0 = 7.
  - Writeback R7 with a same-cycle read → HAZARD stays 1 (P = 3).
  - After two more writebacks, P = 1, and a bypass-hit read gives HAZARD = 0.
- Issue and writeback R9 in the same cycle with P[9] = 1 → P[9] stays 1 and HAZARD stays 1 next cycle. Writeback R10 with P[10] = 0 → data written and WB_ERR = 1, held until reset_n is low at an edge.
- Assert reset_n low while P[3] = 2 together with RF_WRITE to R3 → no write occurs, and P[3] = 0 and RA = 0 afterwards.
